// File: rtl/imem_loader.sv
// imem_loader
//
// Assembles a little-endian byte stream into 32-bit instruction words and
// writes them, one per WRITE cycle, into an instruction memory starting at
// word address 0.
//
// Build option:
//   IMEM_LOADER_CHECKSUM_EN  when defined, checksum accumulates a modulo-2^32
//                            sum of every written word. When undefined,
//                            checksum is tied to 0 and no adder is built.
//
// Parameters:
//   DEPTH      number of 32-bit words in the target memory (== 2**ADDR_W)
//   ADDR_W     word-address width
//
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   start      begin a load (sampled only in IDLE)
//   num_words  words to load, latched on accepted start (0 or >DEPTH -> DEPTH)
//   s_valid    byte-stream valid
//   s_data     byte-stream data
//   s_ready    byte-stream ready (high only in ASSEMBLE)
//   wr_en      one-cycle memory write strobe
//   wr_addr    word address of the write
//   wr_data    word being written
//   busy       high in every state except IDLE
//   done       one-cycle completion pulse
//   last_flag  sticky, set once address DEPTH-1 has been written
//   checksum   running sum of written words (see build option)

module imem_loader #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   num_words,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              busy,
  output logic              done,
  output logic              last_flag,
  output logic [31:0]       checksum
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ASSEMBLE = 2'd1,
    WRITE    = 2'd2,
    DONE     = 2'd3
  } state_t;

  localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   ONE_W     = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t              state;
  state_t              next_state;

  logic [ADDR_W:0]     count;          // latched, clamped word count
  logic [ADDR_W:0]     count_clamped;
  logic [ADDR_W-1:0]   idx;            // index of the word being assembled
  logic [1:0]          byte_cnt;       // next byte lane to fill
  logic [23:0]         asm_word;       // lanes 0..2; lane 3 goes straight to wr_data
  logic                accept;
  logic                last_word;

  // ---------------------------------------------------------------------------
  // Combinational decode
  // ---------------------------------------------------------------------------
  always_comb begin
    count_clamped = num_words;
    if ((num_words == '0) || (num_words > DEPTH_W)) begin
      count_clamped = DEPTH_W;
    end
  end

  always_comb begin
    accept    = (state == ASSEMBLE) && s_valid && s_ready;
    last_word = (({1'b0, idx} + ONE_W) == count);
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) begin
          next_state = ASSEMBLE;
        end
      end
      ASSEMBLE: begin
        if (accept && (byte_cnt == 2'd3)) begin
          next_state = WRITE;
        end
      end
      WRITE: begin
        next_state = last_word ? DONE : ASSEMBLE;
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State, datapath and registered outputs
  // ---------------------------------------------------------------------------
  // Status outputs are registered from next_state so each one is valid in the
  // same cycle as the state it describes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      s_ready   <= 1'b0;
      wr_en     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      last_flag <= 1'b0;
      count     <= '0;
      idx       <= '0;
      byte_cnt  <= '0;
      asm_word  <= '0;
    end else begin
      state   <= next_state;
      s_ready <= (next_state == ASSEMBLE);
      wr_en   <= (next_state == WRITE);
      busy    <= (next_state != IDLE);
      done    <= (next_state == DONE);

      case (state)
        IDLE: begin
          if (start) begin
            count     <= count_clamped;
            idx       <= '0;
            byte_cnt  <= '0;
            asm_word  <= '0;
            last_flag <= 1'b0;
          end
        end

        ASSEMBLE: begin
          if (accept) begin
            byte_cnt <= byte_cnt + 2'd1;
            case (byte_cnt)
              2'd0: asm_word[7:0]   <= s_data;
              2'd1: asm_word[15:8]  <= s_data;
              2'd2: asm_word[23:16] <= s_data;
              default: begin
                // Final byte: complete the word directly into the write
                // register so WRITE can present it on the very next cycle.
                wr_data <= {s_data, asm_word};
                wr_addr <= idx;
              end
            endcase
          end
        end

        WRITE: begin
          if (wr_addr == LAST_ADDR) begin
            last_flag <= 1'b1;
          end
          if (!last_word) begin
            idx <= idx + 1'b1;
          end
        end

        default: begin
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Optional checksum
  // ---------------------------------------------------------------------------
`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      checksum <= '0;
    end else if ((state == IDLE) && start) begin
      checksum <= '0;
    end else if (state == WRITE) begin
      checksum <= checksum + wr_data;
    end
  end
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [ADDR_W:0]   num_words;
  logic              s_valid;
  logic [7:0]        s_data;
  logic              s_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              busy;
  logic              done;
  logic              last_flag;
  logic [31:0]       checksum;

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num_words (num_words),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_ready   (s_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done),
    .last_flag (last_flag),
    .checksum  (checksum)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;
  int st_cyc   = 0;

  // Observed write / done events
  int          w_addr[$];
  logic [31:0] w_data[$];
  int          w_cyc[$];
  logic        w_lf[$];
  int          d_cyc[$];

  // Reference: words the loader is expected to write, in address order
  logic [31:0] exp_q[$];

  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      w_addr.push_back(int'(wr_addr));
      w_data.push_back(wr_data);
      w_cyc.push_back(cyc);
      w_lf.push_back(last_flag);
    end
    if (done === 1'b1) d_cyc.push_back(cyc);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int eff_count(input int n);
    return (n == 0 || n > DEPTH) ? DEPTH : n;
  endfunction

  task automatic clear_mon();
    w_addr.delete(); w_data.delete(); w_cyc.delete(); w_lf.delete(); d_cyc.delete();
  endtask

  task automatic fill_random(input int cnt);
    exp_q.delete();
    for (int i = 0; i < cnt; i++) exp_q.push_back($urandom);
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic do_start(input int n);
    start     = 1'b1;
    num_words = (ADDR_W + 1)'(n);
    st_cyc    = cyc;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    s_valid = 1'b1;
    s_data  = b;
    while (s_ready !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) begin
      chk("s_ready_timeout", 64'(s_ready), 64'd1);
      s_valid = 1'b0;
      return;
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap, input int gap2);
    logic [31:0] tmp;
    int g;
    tmp = w;
    for (int k = 0; k < 4; k++) begin
      g = (k == 2) ? gap2 : 0;
      if (max_gap > 0) g += int'($urandom_range(max_gap, 0));
      repeat (g) @(negedge clk);
      send_byte(tmp[8*k +: 8]);
    end
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 64'(done), 64'd1);
    repeat (4) @(negedge clk);
  endtask

  task automatic verify(input int cnt, input bit timing, input int gap2);
    logic [31:0] sum;
    int nw;
    sum = '0;
    foreach (exp_q[i]) sum += exp_q[i];
    nw = (w_addr.size() < cnt) ? w_addr.size() : cnt;
    chk("n_writes", 64'(w_addr.size()), 64'(cnt));
    for (int i = 0; i < nw; i++) begin
      chk($sformatf("wr_addr[%0d]", i), 64'(w_addr[i]), 64'(i));
      chk($sformatf("wr_data[%0d]", i), 64'(w_data[i]), 64'(exp_q[i]));
      if (timing)
        chk($sformatf("wr_cyc[%0d]", i), 64'(w_cyc[i] - st_cyc), 64'((5 + gap2) * (i + 1)));
    end
    chk("n_done", 64'(d_cyc.size()), 64'd1);
    if (timing && d_cyc.size() > 0)
      chk("done_cyc", 64'(d_cyc[0] - st_cyc), 64'((5 + gap2) * cnt + 1));
    chk("last_flag", 64'(last_flag), 64'(cnt == DEPTH));
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk("checksum", 64'(checksum), 64'(sum));
`else
    chk("checksum", 64'(checksum), 64'd0);
`endif
    chk("busy_idle", 64'(busy), 64'd0);
  endtask

  task automatic run_load(input int n, input int max_gap, input int gap2, input bit timing);
    int cnt;
    cnt = eff_count(n);
    clear_mon();
    do_start(n);
    for (int i = 0; i < cnt; i++) send_word(exp_q[i], max_gap, gap2);
    wait_done(64);
    verify(cnt, timing, gap2);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; num_words = '0; s_valid = 1'b0; s_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_s_ready",  64'(s_ready),   64'd0);
    chk("rst_wr_en",    64'(wr_en),     64'd0);
    chk("rst_wr_addr",  64'(wr_addr),   64'd0);
    chk("rst_wr_data",  64'(wr_data),   64'd0);
    chk("rst_busy",     64'(busy),      64'd0);
    chk("rst_done",     64'(done),      64'd0);
    chk("rst_last",     64'(last_flag), 64'd0);
    chk("rst_checksum", 64'(checksum),  64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single word 0x00000013, continuous bytes
    exp_q.delete(); exp_q.push_back(32'h0000_0013);
    run_load(1, 0, 0, 1'b1);

    // Three words, continuous bytes: writes 5 cycles apart
    fill_random(3);
    run_load(3, 0, 0, 1'b1);

    // num_words = 0 loads the full memory
    fill_random(DEPTH);
    run_load(0, 0, 0, 1'b1);
    if (w_lf.size() == DEPTH) chk("last_flag_before_255", 64'(w_lf[DEPTH-1]), 64'd0);

    // num_words above DEPTH clamps to DEPTH
    fill_random(DEPTH);
    run_load(300, 0, 0, 1'b0);

    // Three idle cycles between bytes 1 and 2 delay the write by 3
    fill_random(1);
    run_load(1, 0, 3, 1'b1);

    // Reset after two bytes of the first word: no write, back to idle
    clear_mon();
    do_start(2);
    send_byte(8'hAA);
    send_byte(8'hBB);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy",    64'(busy),    64'd0);
    chk("abort_s_ready", 64'(s_ready), 64'd0);
    repeat (8) @(negedge clk);
    chk("abort_writes",  64'(w_addr.size()), 64'd0);
    chk("abort_done",    64'(d_cyc.size()),  64'd0);
    fill_random(1);
    run_load(1, 0, 0, 1'b1);

    // Start pulsed during a load is ignored
    fill_random(2);
    clear_mon();
    do_start(2);
    send_word(exp_q[0], 0, 0);
    start = 1'b1; num_words = 9'd1;
    @(negedge clk);
    start = 1'b0;
    send_byte(exp_q[1][7:0]);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_byte(exp_q[1][15:8]);
    send_byte(exp_q[1][23:16]);
    send_byte(exp_q[1][31:24]);
    wait_done(64);
    verify(2, 1'b0, 0);

    // Randomized loads with random stream gaps
    for (int t = 0; t < 4; t++) begin
      int n;
      n = int'($urandom_range(10, 1));
      fill_random(n);
      run_load(n, 2, 0, 1'b0);
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
